// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider: operand width, opcodes, FSM states.
// DIV_EARLY_EXIT_EN (see div.sv) changes timing only; nothing here depends on it.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        DIV_DIV,
        DIV_DIVU,
        DIV_MOD,
        DIV_MODU
    } div_opcode_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    // Two's-complement negate when neg is set, identity otherwise.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// EX-stage <-> divider bus: start request, flush, and the busy/ok/result response.
// Handshake: valid is a start request sampled at posedge and only taken when the unit
// is not busy and flush is low; it is never queued. ok is a one-cycle result strobe,
// never high together with busy; result holds until the next accepted request.
interface div_if;
    import div_pkg::*;

    logic                    valid;
    div_opcode_t             opcode;
    logic [WIDTH-1:0]        src1;
    logic [WIDTH-1:0]        src2;
    logic                    flush;
    logic                    busy;
    logic                    ok;
    logic [WIDTH-1:0]        result;
    div_state_t              state;

    modport master (
        output valid, opcode, src1, src2, flush,
        input  busy, ok, result, state
    );

    modport slave (
        input  valid, opcode, src1, src2, flush,
        output busy, ok, result, state
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes (purely combinational).
// Shifts rem:quo left by one, trial-subtracts the divisor and keeps the difference when it does not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    // rem < divisor keeps shifted below 2*divisor, so diff's top bit is a pure borrow flag.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign borrow   = diff[WIDTH];
    assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div.sv
// Iterative 32-bit divider for div.w/div.wu/mod.w/mod.wu: restoring magnitude division plus sign fixup.
// Optional DIV_EARLY_EXIT_EN: skip the iterations when |src1| < |src2| (timing only, results unchanged).
module div
    import div_pkg::*;
(
    input logic  clk,
    input logic  resetn,
    div_if.slave bus
);

    div_state_t         state_q;
    div_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   result_q;
    div_opcode_t        op_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               skip_q;

    logic               accept;
    logic               sgn_op;
    logic               s1_neg;
    logic               s2_neg;
    logic               early;
    logic               op_is_mod;
    logic               busy;
    logic               ok;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept = bus.valid && !bus.flush &&
                    ((state_q == DIV_IDLE) || (state_q == DIV_DONE));
    assign sgn_op = (bus.opcode == DIV_DIV) || (bus.opcode == DIV_MOD);
    assign s1_neg = sgn_op && bus.src1[WIDTH-1];
    assign s2_neg = sgn_op && bus.src2[WIDTH-1];
    assign mag1   = cond_neg(bus.src1, s1_neg);
    assign mag2   = cond_neg(bus.src2, s2_neg);

`ifdef DIV_EARLY_EXIT_EN
    assign early = (bus.src2 != '0) && (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    assign op_is_mod = (op_q == DIV_MOD) || (op_q == DIV_MODU);
    assign quo_fix   = cond_neg(quo_q, neg_quo_q);
    assign rem_fix   = cond_neg(rem_q, neg_rem_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        ok      = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (accept) state_d = DIV_CALC;
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                busy    = 1'b1;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                ok      = 1'b1;
                state_d = accept ? DIV_CALC : DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (bus.flush) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            op_q      <= DIV_DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= bus.opcode;
                dvsr_q    <= mag2;
                // Divide-by-zero quotient stays all-ones regardless of operand signs.
                neg_quo_q <= (s1_neg ^ s2_neg) && (bus.src2 != '0);
                neg_rem_q <= s1_neg;
                skip_q    <= early;
                if (early) begin
                    rem_q <= mag1;
                    quo_q <= '0;
                    cnt_q <= '0;
                end else begin
                    rem_q <= '0;
                    quo_q <= mag1;
                    cnt_q <= CNT_W'(WIDTH - 1);
                end
            end else if ((state_q == DIV_CALC) && !skip_q) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if ((state_q == DIV_FIX) && !bus.flush) begin
                result_q <= op_is_mod ? rem_fix : quo_fix;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.ok     = ok;
    assign bus.result = result_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: hand-computed quotients/remainders, latency, flush, reset and back-to-back cases.
module tb_div;
    import div_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    div_if bus();

    div dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input div_opcode_t op, input logic [31:0] a, input logic [31:0] b);
        bus.valid  = 1'b1;
        bus.opcode = op;
        bus.src1   = a;
        bus.src2   = b;
        step();
        bus.valid  = 1'b0;
    endtask

    // Issues one op and waits for ok; poke>0 pulses a stray valid in that busy cycle.
    task automatic run_op(input string tag, input div_opcode_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit early_ok,
                          input int poke);
        int n;
        int busy_n;
        int exp_lat;
        bit seen;
        exp_lat = (EARLY && early_ok) ? 3 : 34;
        issue(op, a, b);
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n <= 60) begin
            if (bus.busy) busy_n++;
            if (bus.ok) begin
                seen = 1'b1;
                check({tag, " busy_at_ok"}, 32'(bus.busy), 32'd0);
            end else begin
                if (n == poke) begin
                    bus.valid  = 1'b1;
                    bus.opcode = DIV_MOD;
                    bus.src1   = 32'd1;
                    bus.src2   = 32'd1;
                end else begin
                    bus.valid = 1'b0;
                end
                step();
                n++;
            end
        end
        bus.valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check({tag, " result"}, bus.result, exp);
    endtask

    initial begin
        resetn     = 1'b0;
        bus.valid  = 1'b0;
        bus.flush  = 1'b0;
        bus.opcode = DIV_DIV;
        bus.src1   = '0;
        bus.src2   = '0;
        step();
        step();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst ok", 32'(bus.ok), 32'd0);
        check("rst result", bus.result, 32'd0);
        check("rst state", 32'(bus.state), 32'(DIV_IDLE));
        resetn = 1'b1;
        step();

        run_op("div_100_7", DIV_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 0);
        // Issued in the ok cycle of the previous op: back-to-back acceptance.
        run_op("mod_100_7", DIV_MOD, 32'd100, 32'd7, 32'd2, 1'b0, 0);
        step();
        check("hold ok", 32'(bus.ok), 32'd0);
        check("hold result", bus.result, 32'd2);
        check("hold state", 32'(bus.state), 32'(DIV_IDLE));

        run_op("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("mod_m7_2", DIV_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("modu_7_m2", DIV_MODU, 32'd7, 32'hFFFF_FFFE, 32'd7, 1'b1, 0);
        run_op("divu_5_0", DIV_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mod_5_0", DIV_MOD, 32'd5, 32'd0, 32'd5, 1'b0, 0);
        run_op("div_m5_0", DIV_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mod_m5_0", DIV_MOD, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, 0);
        run_op("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        run_op("mod_ovf", DIV_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        run_op("divu_3_9", DIV_DIVU, 32'd3, 32'd9, 32'd0, 1'b1, 0);
        run_op("divu_max_2", DIV_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0, 0);
        run_op("div_m1_2", DIV_DIV, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1, 0);
        run_op("div_7_m2", DIV_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("mod_7_m2", DIV_MOD, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
        step();

        // Stray valid while busy must not restart or alter the running op.
        run_op("divu_poke", DIV_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 5);
        step();

        // Flush sampled at edge T+10 of a running op.
        issue(DIV_DIV, 32'd100, 32'd7);
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush ok", 32'(bus.ok), 32'd0);
        check("flush state", 32'(bus.state), 32'(DIV_IDLE));
        check("flush result", bus.result, 32'd100);
        run_op("after_flush", DIV_MOD, 32'd100, 32'd7, 32'd2, 1'b0, 0);
        step();

        // Flush wins over a simultaneous start request.
        bus.valid  = 1'b1;
        bus.flush  = 1'b1;
        bus.opcode = DIV_DIV;
        bus.src1   = 32'd50;
        bus.src2   = 32'd5;
        step();
        bus.valid = 1'b0;
        bus.flush = 1'b0;
        check("flush_vs_valid busy", 32'(bus.busy), 32'd0);
        step();
        check("flush_vs_valid ok", 32'(bus.ok), 32'd0);
        check("flush_vs_valid result", bus.result, 32'd2);

        // Reset in the middle of CALC discards the op and clears result.
        issue(DIV_DIVU, 32'd1000, 32'd3);
        repeat (5) step();
        resetn = 1'b0;
        step();
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst ok", 32'(bus.ok), 32'd0);
        check("midrst result", bus.result, 32'd0);
        check("midrst state", 32'(bus.state), 32'(DIV_IDLE));
        resetn = 1'b1;
        step();
        run_op("after_rst", DIV_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
